fifo_pop_stream: RTL



---
 rtl/fifo_pop_stream.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_pop_stream.sv
// Pop/valid FIFO read port to valid/ready stream adapter with a DEPTH-entry buffer and credit-based pop issue.
// Optional flush port enabled by defining FIFO_POP_STREAM_FLUSH_EN.
module fifo_pop_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef FIFO_POP_STREAM_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       fifo_empty,
  output logic                       fifo_pop,
  input  logic                       fifo_valid,
  input  logic [WIDTH-1:0]           fifo_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       err
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             inflight_q, inflight_d;
  logic             err_q, err_d;
  logic [LW:0]      resv_c;
  logic             flush_c, drop_late_c;
  logic             deq_c, arrive_c, full_c, wr_en_c;

`ifdef FIFO_POP_STREAM_FLUSH_EN
  // A pop outstanding at flush may return one cycle late; swallow it silently.
  logic discard_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) discard_q <= 1'b0;
    else     discard_q <= flush && inflight_q;
  end
  assign flush_c     = flush;
  assign drop_late_c = discard_q;
`else
  assign flush_c     = 1'b0;
  assign drop_late_c = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reservation counts buffered words plus the one possibly on its way back.
  assign resv_c    = {1'b0, level_q} + (LW+1)'(inflight_q);
  assign fifo_pop  = !fifo_empty && (resv_c < (LW+1)'(DEPTH)) && !rst && !flush_c;
  assign out_valid = (level_q != '0) && !flush_c;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign err       = err_q;

  assign deq_c    = out_valid && out_ready;
  assign arrive_c = fifo_valid && inflight_q;
  assign full_c   = (level_q == LW'(DEPTH));
  assign wr_en_c  = arrive_c && (!full_c || deq_c) && !flush_c;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    inflight_d = fifo_pop;
    err_d      = err_q;
    if (wr_en_c) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq_c)   rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_en_c, deq_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (fifo_valid && !inflight_q && !drop_late_c) err_d = 1'b1;
    if (arrive_c && full_c && !deq_c && !flush_c)   err_d = 1'b1;
    if (flush_c) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q] <= fifo_rdata;
    end
  end

endmodule
